// File: rtl/tc_pkg.sv
// Shared constants and helpers for the TinyComp input-port arbiter.
package tc_pkg;
  localparam int TC_WORD_W   = 32;
  localparam int TC_NREQ_MAX = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction
endpackage

// File: rtl/tc_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module tc_rr_pick #(
  parameter int NREQ = 4,
  parameter int SRCW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [SRCW-1:0] ptr,
  output logic            gnt_any,
  output logic [SRCW-1:0] gnt_idx
);
  logic [NREQ-1:0] rot;
  int              sum;

  // Doubling the vector turns the wrap-around search into a plain rotate.
  assign rot     = NREQ'({req, req} >> ptr);
  assign gnt_any = |req;

  always_comb begin
    gnt_idx = '0;
    sum     = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum = int'(ptr) + j;
        if (sum >= NREQ) sum = sum - NREQ;
        gnt_idx = SRCW'(sum);
      end
    end
  end
endmodule

// File: rtl/tc_in_arbiter.sv
// Shares TinyComp's single input port between NREQ producers: per-producer
// one-entry holding registers feed a registered presentation stage via round-robin.
module tc_in_arbiter import tc_pkg::*; #(
  parameter int NREQ    = 4,
  parameter int SRCW    = clog2(NREQ),
  parameter int TAG_SRC = 0
) (
  input  logic                        Ph0,
  input  logic                        Reset,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*TC_WORD_W-1:0]   req_data,
  output logic [NREQ-1:0]             req_ready,
  input  logic                        InStrobe,
  output logic [TC_WORD_W-1:0]        InData,
  output logic                        InRdy,
  output logic [SRCW-1:0]             InSrc,
  output logic                        underrun,
  input  logic                        clr_under
);
  logic [NREQ-1:0]                hold_v;
  logic [NREQ-1:0][TC_WORD_W-1:0] hold_d;
  logic [SRCW-1:0]                rr_ptr, gnt_idx, nxt_ptr;
  logic                           gnt_any, load;
  logic [TC_WORD_W-1:0]           pres_word;

  tc_rr_pick #(.NREQ(NREQ), .SRCW(SRCW)) u_pick (
    .req     (hold_v),
    .ptr     (rr_ptr),
    .gnt_any (gnt_any),
    .gnt_idx (gnt_idx)
  );

  // Ready is purely registered state so InStrobe never reaches producers combinationally.
  assign req_ready = ~hold_v;
  assign load      = (~InRdy | InStrobe) & gnt_any;
  assign nxt_ptr   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    pres_word = hold_d[gnt_idx];
    if (TAG_SRC != 0) pres_word[TC_WORD_W-1 -: SRCW] = gnt_idx;
  end

  always_ff @(posedge Ph0 or posedge Reset) begin
    if (Reset) begin
      hold_v   <= '0;
      hold_d   <= '0;
      InData   <= '0;
      InRdy    <= 1'b0;
      InSrc    <= '0;
      rr_ptr   <= '0;
      underrun <= 1'b0;
    end else begin
      // Accept and grant touch disjoint slots: accept needs empty, grant needs full.
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !hold_v[i]) begin
          hold_v[i] <= 1'b1;
          hold_d[i] <= req_data[TC_WORD_W*i +: TC_WORD_W];
        end
      end
      if (load) begin
        hold_v[gnt_idx] <= 1'b0;
        InData          <= pres_word;
        InSrc           <= gnt_idx;
        InRdy           <= 1'b1;
        rr_ptr          <= nxt_ptr;
      end else if (InStrobe && InRdy) begin
        InRdy <= 1'b0;
      end
      if (InStrobe && !InRdy) underrun <= 1'b1;
      else if (clr_under)     underrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tc_in_arbiter.sv
// Self-checking bench for tc_in_arbiter: directed scenarios plus random traffic
// compared against a slot/queue-level reference model.
module tb_tc_in_arbiter;
  logic         Ph0 = 1'b0;
  logic         Reset = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_data = '0;
  logic         InStrobe = 1'b0;
  logic         clr_under = 1'b0;
  logic [3:0]   req_ready, req_ready_t;
  logic [31:0]  InData, InData_t;
  logic         InRdy, InRdy_t;
  logic [1:0]   InSrc, InSrc_t;
  logic         underrun, underrun_t;

  int total = 0;
  int bad = 0;

  always #5 Ph0 = ~Ph0;

  tc_in_arbiter #(.NREQ(4), .SRCW(2), .TAG_SRC(0)) dut (
    .Ph0(Ph0), .Reset(Reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .InStrobe(InStrobe), .InData(InData), .InRdy(InRdy),
    .InSrc(InSrc), .underrun(underrun), .clr_under(clr_under)
  );

  tc_in_arbiter #(.NREQ(4), .SRCW(2), .TAG_SRC(1)) dut_t (
    .Ph0(Ph0), .Reset(Reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_t), .InStrobe(InStrobe), .InData(InData_t), .InRdy(InRdy_t),
    .InSrc(InSrc_t), .underrun(underrun_t), .clr_under(clr_under)
  );

  // Reference model: slots, a presented word and a rotating search start.
  logic [3:0]  mv;
  logic [31:0] md [4];
  logic        m_rdy, m_under;
  logic [31:0] m_data;
  logic [1:0]  m_src, m_ptr;
  logic [3:0]  acc;
  int          g, idx;
  bit          ld;

  always @(posedge Ph0 or posedge Reset) begin
    if (Reset) begin
      mv = '0; m_rdy = 0; m_under = 0; m_data = '0; m_src = '0; m_ptr = '0;
      for (int i = 0; i < 4; i++) md[i] = '0;
    end else begin
      acc = req_valid & ~mv;
      ld  = (!m_rdy || InStrobe) && (mv != 0);
      if (InStrobe && !m_rdy) m_under = 1;
      else if (clr_under)     m_under = 0;
      if (ld) begin
        g = -1;
        for (int k = 0; k < 4; k++) begin
          idx = (int'(m_ptr) + k) % 4;
          if (g < 0 && mv[idx]) g = idx;
        end
        m_data = md[g]; m_src = 2'(g); m_rdy = 1; mv[g] = 0; m_ptr = 2'((g + 1) % 4);
      end else if (InStrobe && m_rdy) begin
        m_rdy = 0;
      end
      for (int i = 0; i < 4; i++)
        if (acc[i]) begin mv[i] = 1; md[i] = req_data[32*i +: 32]; end
    end
  end

  task automatic tick();
    @(negedge Ph0);
  endtask

  task automatic do_reset();
    req_valid = '0; InStrobe = 0; clr_under = 0;
    Reset = 1;
    tick();
    Reset = 0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    total++; if (InRdy !== 1'b0)   begin bad++; $display("FAIL reset_inrdy got=%b exp=0", InRdy); end
    total++; if (InData !== 32'h0) begin bad++; $display("FAIL reset_indata got=%h exp=0", InData); end
    total++; if (InSrc !== 2'd0)   begin bad++; $display("FAIL reset_insrc got=%0d exp=0", InSrc); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    Reset = 0;
    tick();
    total++; if (req_ready !== 4'hF) begin bad++; $display("FAIL reset_ready got=%h exp=f", req_ready); end
  endtask

  task automatic test_single();
    req_valid = 4'b0100; req_data[64 +: 32] = 32'hDEADBEEF;
    tick();
    req_valid = '0;
    total++; if (req_ready[2] !== 1'b0) begin bad++; $display("FAIL single_held got=%b exp=0", req_ready[2]); end
    total++; if (InRdy !== 1'b0)        begin bad++; $display("FAIL single_early got=%b exp=0", InRdy); end
    tick();
    total++; if (InRdy !== 1'b1)          begin bad++; $display("FAIL single_rdy got=%b exp=1", InRdy); end
    total++; if (InData !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data got=%h exp=deadbeef", InData); end
    total++; if (InSrc !== 2'd2)          begin bad++; $display("FAIL single_src got=%0d exp=2", InSrc); end
    total++; if (req_ready[2] !== 1'b1)   begin bad++; $display("FAIL single_ready got=%b exp=1", req_ready[2]); end
    InStrobe = 1;
    tick();
    InStrobe = 0;
    total++; if (InRdy !== 1'b0) begin bad++; $display("FAIL single_consume got=%b exp=0", InRdy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) req_data[32*i +: 32] = 32'h10 + i;
    tick();
    req_valid = '0;
    tick();
    total++; if (InData !== 32'h10) begin bad++; $display("FAIL b2b_first got=%h exp=10", InData); end
    InStrobe = 1;
    for (int i = 1; i < 4; i++) begin
      tick();
      total++; if (InData !== 32'h10 + i || InRdy !== 1'b1)
        begin bad++; $display("FAIL b2b_seq%0d got=%h/%b exp=%h/1", i, InData, InRdy, 32'h10 + i); end
      total++; if (InData_t !== ({2'(i), 30'h10 + 30'(i)}))
        begin bad++; $display("FAIL b2b_tag%0d got=%h", i, InData_t); end
    end
    tick();
    InStrobe = 0;
    total++; if (InRdy !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", InRdy); end
  endtask

  task automatic test_underrun();
    logic [31:0] keep;
    keep = InData;
    InStrobe = 1;
    tick();
    InStrobe = 0;
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL under_set got=%b exp=1", underrun); end
    total++; if (InData !== keep)   begin bad++; $display("FAIL under_data got=%h exp=%h", InData, keep); end
    clr_under = 1;
    tick();
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL under_clr got=%b exp=0", underrun); end
    InStrobe = 1;
    tick();
    InStrobe = 0; clr_under = 0;
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL under_setwins got=%b exp=1", underrun); end
    clr_under = 1;
    tick();
    clr_under = 0;
  endtask

  task automatic test_tag();
    req_valid = 4'b0010; req_data[32 +: 32] = 32'hFFFFFFFF;
    tick();
    req_valid = '0;
    tick();
    total++; if (InData_t !== 32'h7FFFFFFF) begin bad++; $display("FAIL tag_data got=%h exp=7fffffff", InData_t); end
    total++; if (InSrc_t !== 2'd1)          begin bad++; $display("FAIL tag_src got=%0d exp=1", InSrc_t); end
    total++; if (InData !== 32'hFFFFFFFF)   begin bad++; $display("FAIL untag_data got=%h exp=ffffffff", InData); end
    InStrobe = 1;
    tick();
    InStrobe = 0;
  endtask

  task automatic test_fairness();
    int grants, first3, cnt3;
    do_reset();
    grants = 0; first3 = 0; cnt3 = 0;
    InStrobe = 1;
    req_valid = 4'b1001; req_data[0 +: 32] = 32'hA0; req_data[96 +: 32] = 32'hB3;
    for (int c = 0; c < 8; c++) begin
      tick();
      req_valid = 4'b0001; req_data[0 +: 32] = 32'hA1 + c;
      if (InRdy) begin
        grants++;
        if (InSrc == 2'd3 && first3 == 0) first3 = grants;
      end
    end
    total++; if (first3 < 1 || first3 > 2) begin bad++; $display("FAIL fair_first got=%0d exp=1..2", first3); end
    req_valid = 4'b1001;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (InRdy && InSrc == 2'd3) cnt3++;
    end
    total++; if (cnt3 < 5) begin bad++; $display("FAIL fair_starve got=%0d exp>=5", cnt3); end
    req_valid = '0; InStrobe = 0;
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    InStrobe = 1; req_valid = 4'b0010; req_data[32 +: 32] = 32'h55;
    tick();
    InStrobe = 0; req_valid = '0;
    tick();
    req_valid = 4'b1001; req_data[0 +: 32] = 32'h600; req_data[96 +: 32] = 32'h633;
    tick();
    req_valid = '0;
    #2 Reset = 1;
    #1;
    total++; if (InRdy !== 1'b0)     begin bad++; $display("FAIL areset_rdy got=%b exp=0", InRdy); end
    total++; if (req_ready !== 4'hF) begin bad++; $display("FAIL areset_holds got=%h exp=f", req_ready); end
    total++; if (underrun !== 1'b0)  begin bad++; $display("FAIL areset_under got=%b exp=0", underrun); end
    tick();
    Reset = 0;
    req_valid = 4'b1001;
    tick();
    req_valid = '0;
    tick();
    total++; if (InSrc !== 2'd0 || InData !== 32'h600)
      begin bad++; $display("FAIL areset_first got=%0d/%h exp=0/600", InSrc, InData); end
  endtask

  task automatic test_random();
    logic [31:0] exp_t;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) req_data[32*i +: 32] = $urandom;
      InStrobe  = ($urandom_range(2) != 0);
      clr_under = ($urandom_range(7) == 0);
      tick();
      exp_t = {m_src, m_data[29:0]};
      total++; if (req_ready !== ~mv) begin bad++; $display("FAIL rnd_ready c=%0d got=%h exp=%h", c, req_ready, ~mv); end
      total++; if (InRdy !== m_rdy)   begin bad++; $display("FAIL rnd_rdy c=%0d got=%b exp=%b", c, InRdy, m_rdy); end
      total++; if (InData !== m_data) begin bad++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, InData, m_data); end
      total++; if (InSrc !== m_src)   begin bad++; $display("FAIL rnd_src c=%0d got=%0d exp=%0d", c, InSrc, m_src); end
      total++; if (underrun !== m_under) begin bad++; $display("FAIL rnd_under c=%0d got=%b exp=%b", c, underrun, m_under); end
      total++; if (InData_t !== exp_t || InRdy_t !== m_rdy)
        begin bad++; $display("FAIL rnd_tag c=%0d got=%h/%b exp=%h/%b", c, InData_t, InRdy_t, exp_t, m_rdy); end
    end
    req_valid = '0; InStrobe = 0; clr_under = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_tag();
    test_fairness();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
